// File: rtl/clock_en_gen.sv
// Fractional-rate clock enables gated by a synchronised, hold-qualified PLL lock; `LOCK_LOSS_CNT_EN adds lock_loss_cnt.
// Latency: lock rise to ready takes SYNC_STAGES+1+LOCK_HOLD edges; no backpressure, strobes free-run in RUN.
module clock_en_gen #(
  parameter int CHANNELS    = 2,
  parameter int ACC_W       = 24,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_HOLD   = 1024
) (
  input  logic                      clk_pix,
  input  logic                      rst,
  input  logic                      pll_lock_async,
  input  logic [CHANNELS*ACC_W-1:0] inc,
  output logic                      ready,
  output logic [CHANNELS-1:0]       stb
`ifdef LOCK_LOSS_CNT_EN
  ,
  output logic [7:0]                lock_loss_cnt
`endif
);

  localparam int HC_W = $clog2(LOCK_HOLD + 1);

  generate
    if (LOCK_HOLD < 1 || SYNC_STAGES < 2 || ACC_W < 2 || ACC_W > 32 || CHANNELS < 1) begin : g_bad_param
      $error("clock_en_gen: illegal parameters");
    end
  endgenerate

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0]          sync_q, sync_d;
  logic                            lock_s;
  state_t                          state_q, state_d;
  logic [HC_W-1:0]                 hold_cnt_q, hold_cnt_d;
  logic                            ready_q, ready_d;
  logic [CHANNELS-1:0]             stb_q, stb_d;
  logic [CHANNELS-1:0][ACC_W-1:0]  acc_q, acc_d;
  logic [CHANNELS-1:0][ACC_W:0]    sum;

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pll_lock_async};
  end

  // One extra bit per channel: the carry out is the strobe.
  always_comb begin
    sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sum[i] = {1'b0, acc_q[i]} + {1'b0, inc[i*ACC_W +: ACC_W]};
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    acc_d      = '0;
    stb_d      = '0;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (hold_cnt_q == HC_W'(LOCK_HOLD - 1)) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else begin
          for (int i = 0; i < CHANNELS; i++) begin
            acc_d[i] = sum[i][ACC_W-1:0];
            stb_d[i] = sum[i][ACC_W];
          end
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
    ready_d = (state_d == RUN);
  end

`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (state_q == RUN && !lock_s && loss_cnt_q != 8'hFF) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`endif

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      sync_q     <= '0;
      state_q    <= WAIT_LOCK;
      hold_cnt_q <= '0;
      ready_q    <= 1'b0;
      stb_q      <= '0;
      acc_q      <= '0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      ready_q    <= ready_d;
      stb_q      <= stb_d;
      acc_q      <= acc_d;
    end
  end

  assign ready = ready_q;
  assign stb   = stb_q;

endmodule

// File: tb/tb_clock_en_gen.sv
// Randomised bench for clock_en_gen against a run-length lock model and arithmetic phase accumulators.
module tb_clock_en_gen;

  localparam int CH   = 2;
  localparam int AW   = 8;
  localparam int SYNC = 2;
  localparam int LH   = 16;
  localparam int QUAL = SYNC + 1 + LH;

  logic              clk_pix = 1'b0;
  logic              rst = 1'b1;
  logic              pll_lock_async = 1'b0;
  logic [CH*AW-1:0]  inc = '0;
  logic              ready;
  logic [CH-1:0]     stb;
`ifdef LOCK_LOSS_CNT_EN
  logic [7:0]        lock_loss_cnt;
`endif

  always #5 clk_pix = ~clk_pix;

  clock_en_gen #(
    .CHANNELS   (CH),
    .ACC_W      (AW),
    .SYNC_STAGES(SYNC),
    .LOCK_HOLD  (LH)
  ) dut (
    .clk_pix       (clk_pix),
    .rst           (rst),
    .pll_lock_async(pll_lock_async),
    .inc           (inc),
    .ready         (ready),
`ifdef LOCK_LOSS_CNT_EN
    .lock_loss_cnt (lock_loss_cnt),
`endif
    .stb           (stb)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: lock_s is the raw lock delayed SYNC edges; the FSM state is a
  // function of how many consecutive 1s it has seen on lock_s.
  bit            m_hist[$];
  int            m_streak = 0;
  int            m_acc[CH];
  logic          m_ready = 1'b0;
  logic [CH-1:0] m_stb = '0;
  int            m_cnt = 0;

  task automatic step();
    int ls;
    int prev;
    int sum;
    @(posedge clk_pix);
    if (rst) begin
      m_hist.delete();
      for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
      m_streak = 0;
      m_ready  = 1'b0;
      m_stb    = '0;
      m_cnt    = 0;
      for (int c = 0; c < CH; c++) m_acc[c] = 0;
    end else begin
      ls = int'(m_hist.pop_front());
      m_hist.push_back(pll_lock_async);
      prev = m_streak;
      m_streak = (ls != 0) ? ((m_streak < LH + 2) ? m_streak + 1 : m_streak) : 0;
      if (prev >= LH + 1 && ls == 0 && m_cnt < 255) m_cnt++;
      m_ready = (m_streak >= LH + 1);
      for (int c = 0; c < CH; c++) begin
        if (m_streak >= LH + 2) begin
          sum = m_acc[c] + int'(inc[c*AW +: AW]);
          m_stb[c] = (sum >= (1 << AW));
          m_acc[c] = sum % (1 << AW);
        end else begin
          m_stb[c] = 1'b0;
          m_acc[c] = 0;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pll_lock_async = 1'b0;
    step();
    step();
    vectors++;
    if (ready !== 1'b0 || stb !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_state cyc=%0d ready=%b stb=%b required ready=0 stb=00", cyc, ready, stb);
    end
    rst = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      inc = CH*AW'($urandom);
      step();
      vectors++;
      if (ready !== 1'b0 || stb !== 2'b00 || m_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL no_lock_idle cyc=%0d ready=%b stb=%b required ready=0 stb=00", cyc, ready, stb);
      end
    end
  endtask

  task automatic test_lock_timing();
    int n;
    inc = {8'd0, 8'd128};
    pll_lock_async = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    vectors++;
    if (n != QUAL || m_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_to_ready edges=%0d required=%0d", n, QUAL);
    end
    for (int k = 0; k < 20; k++) begin
      step();
      vectors++;
      if (stb[0] !== 1'(k % 2) || stb[1] !== 1'b0 || stb !== m_stb) begin
        miscompares++;
        $display("FAIL half_rate_pattern k=%0d stb=%b required stb0=%0d stb1=0", k, stb, k % 2);
      end
    end
  endtask

  task automatic test_slow_rate();
    int pulses;
    int last;
    int min_gap;
    inc = {AW'($urandom), 8'd3};
    pulses = 0;
    last = -1;
    min_gap = 1000;
    for (int k = 0; k < 256; k++) begin
      step();
      vectors++;
      if (stb !== m_stb || ready !== 1'b1) begin
        miscompares++;
        $display("FAIL slow_rate_model cyc=%0d stb=%b ready=%b required stb=%b ready=1", cyc, stb, ready, m_stb);
      end
      if (stb[0] === 1'b1) begin
        if (last >= 0 && k - last < min_gap) min_gap = k - last;
        last = k;
        pulses++;
      end
    end
    vectors++;
    if (pulses != 3 || min_gap < 85) begin
      miscompares++;
      $display("FAIL slow_rate_count pulses=%0d min_gap=%0d required pulses=3 min_gap>=85", pulses, min_gap);
    end
  endtask

  task automatic test_lock_drop_run();
    int fall;
    int n;
    fall = -1;
    pll_lock_async = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (fall < 0 && ready === 1'b0) fall = k;
    end
    vectors++;
    if (fall != SYNC + 1 || stb !== 2'b00) begin
      miscompares++;
      $display("FAIL run_drop_latency edges=%0d stb=%b required edges=%0d stb=00", fall, stb, SYNC + 1);
    end
    pll_lock_async = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      step();
      n++;
      vectors++;
      if (ready !== m_ready || stb !== m_stb) begin
        miscompares++;
        $display("FAIL requalify_model cyc=%0d ready=%b stb=%b required ready=%b stb=%b", cyc, ready, stb, m_ready, m_stb);
      end
    end
    vectors++;
    if (n != QUAL) begin
      miscompares++;
      $display("FAIL requalify_edges edges=%0d required=%0d", n, QUAL);
    end
`ifdef LOCK_LOSS_CNT_EN
    vectors++;
    if (lock_loss_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL loss_cnt_one got=%0d required=1", lock_loss_cnt);
    end
`endif
  endtask

  task automatic test_hold_drop();
    int n;
    pll_lock_async = 1'b0;
    for (int k = 0; k < 4; k++) step();
    // Lock_s stays high long enough to reach hold_cnt=10, then glitches low.
    pll_lock_async = 1'b1;
    for (int k = 0; k < 11; k++) step();
    pll_lock_async = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      vectors++;
      if (ready !== 1'b0 || ready !== m_ready) begin
        miscompares++;
        $display("FAIL hold_drop_no_ready cyc=%0d ready=%b required 0", cyc, ready);
      end
    end
    pll_lock_async = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    vectors++;
    if (n != QUAL) begin
      miscompares++;
      $display("FAIL hold_restart_edges edges=%0d required=%0d", n, QUAL);
    end
  endtask

  task automatic test_rst_mid_run();
    int n;
    inc = {8'd77, 8'd200};
    for (int k = 0; k < 5; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (ready !== 1'b0 || stb !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_mid_run ready=%b stb=%b required ready=0 stb=00", ready, stb);
    end
`ifdef LOCK_LOSS_CNT_EN
    vectors++;
    if (lock_loss_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL rst_clears_loss_cnt got=%0d required=0", lock_loss_cnt);
    end
`endif
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    vectors++;
    if (n != QUAL) begin
      miscompares++;
      $display("FAIL post_rst_qualify edges=%0d required=%0d", n, QUAL);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      if (pll_lock_async) begin
        if ($urandom_range(0, 59) == 0) pll_lock_async = 1'b0;
      end else begin
        if ($urandom_range(0, 2) == 0) pll_lock_async = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) inc = CH*AW'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      step();
      vectors++;
      if (ready !== m_ready || stb !== m_stb) begin
        miscompares++;
        $display("FAIL random_model cyc=%0d ready=%b stb=%b required ready=%b stb=%b", cyc, ready, stb, m_ready, m_stb);
      end
`ifdef LOCK_LOSS_CNT_EN
      vectors++;
      if (lock_loss_cnt !== 8'(m_cnt)) begin
        miscompares++;
        $display("FAIL random_loss_cnt cyc=%0d got=%0d required=%0d", cyc, lock_loss_cnt, m_cnt);
      end
`endif
    end
    rst = 1'b0;
  endtask

  task automatic test_saturate();
    int n;
    inc = CH*AW'($urandom);
    for (int loss = 0; loss < 300; loss++) begin
      pll_lock_async = 1'b1;
      n = 0;
      while (ready !== 1'b1 && n < 60) begin
        step();
        n++;
      end
      pll_lock_async = 1'b0;
      n = 0;
      while (ready !== 1'b0 && n < 10) begin
        step();
        n++;
      end
      vectors++;
      if (ready !== m_ready || stb !== m_stb) begin
        miscompares++;
        $display("FAIL saturate_model loss=%0d ready=%b stb=%b required ready=%b stb=%b", loss, ready, stb, m_ready, m_stb);
      end
    end
`ifdef LOCK_LOSS_CNT_EN
    vectors++;
    if (lock_loss_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL loss_cnt_saturate got=%0d required=255", lock_loss_cnt);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    for (int c = 0; c < CH; c++) m_acc[c] = 0;
    test_reset();
    test_lock_timing();
    test_slow_rate();
    test_lock_drop_run();
    test_hold_drop();
    test_rst_mid_run();
    test_random();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
